popcount32: RTL and testbench

//   Pipelined population counter: returns the number of '1' bits in a 32-bit word.
//   It is a datapath leaf used wherever a bit-occupancy count is needed (mask

---
 rtl/popcount_pkg.sv | 10 +
 rtl/popcount4.sv | 12 +
 rtl/popcount32.sv | 68 ++++++
 tb/tb_popcount32.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared widths and types for the 32-bit population counter.
package popcount_pkg;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned NIB_CNT_W = 3;
  localparam int unsigned NUM_NIB   = DATA_W / 4;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [NIB_CNT_W-1:0] nib_cnt_t;
endpackage

// File: rtl/popcount4.sv
// Combinational 4-bit population count (result 0..4).
module popcount4
  import popcount_pkg::*;
(
  input  logic [3:0] i_nib,
  output nib_cnt_t   o_cnt
);

  assign o_cnt = {2'b00, i_nib[0]} + {2'b00, i_nib[1]}
               + {2'b00, i_nib[2]} + {2'b00, i_nib[3]};

endmodule

// File: rtl/popcount32.sv
// Two-stage pipelined 32-bit population counter: nibble counts, then adder tree.
module popcount32
  import popcount_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count
);

  nib_cnt_t w_nib_cnt [NUM_NIB];
  nib_cnt_t r_s1_cnt  [NUM_NIB];
  logic     r_s1_valid;
  logic     r_out_valid;
  cnt_t     r_out_count;

  logic [3:0] w_sum4 [4];
  logic [4:0] w_sum5 [2];
  cnt_t       w_sum;

  for (genvar gi = 0; gi < NUM_NIB; gi++) begin : g_nib
    popcount4 u_popcount4 (
      .i_nib (in_data[gi*4 +: 4]),
      .o_cnt (w_nib_cnt[gi])
    );
  end

  // Stage 1: nibble counts; data only captured on valid words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_NIB; i++) r_s1_cnt[i] <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < NUM_NIB; i++) r_s1_cnt[i] <= w_nib_cnt[i];
      end
    end
  end

  // Balanced tree: 8x3b -> 4x4b -> 2x5b -> 1x6b, zero-extended at each level
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_sum4[i] = {1'b0, r_s1_cnt[2*i]} + {1'b0, r_s1_cnt[2*i+1]};
    end
    for (int unsigned i = 0; i < 2; i++) begin
      w_sum5[i] = {1'b0, w_sum4[2*i]} + {1'b0, w_sum4[2*i+1]};
    end
    w_sum = {1'b0, w_sum5[0]} + {1'b0, w_sum5[1]};
  end

  // Stage 2: out_count holds its last result across bubbles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_count <= w_sum;
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_popcount32.sv
// Directed-vector and random scoreboard bench for popcount32.
module tb_popcount32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [5:0]  out_count;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  cnt;
  } vec_t;

  vec_t bnd_vec [4];
  vec_t str_vec [4];

  popcount32 u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] q [$];
    logic       mv1;
    logic       mv2;
    logic [5:0] exp_c;

    checks   = 0;
    failures = 0;

    bnd_vec[0] = '{32'h0000_0000, 6'd0};
    bnd_vec[1] = '{32'h0000_0001, 6'd1};
    bnd_vec[2] = '{32'hFFFF_FFFF, 6'd32};
    bnd_vec[3] = '{32'hFFFF_0000, 6'd16};
    str_vec[0] = '{32'h8000_0001, 6'd2};
    str_vec[1] = '{32'hAAAA_AAAA, 6'd16};
    str_vec[2] = '{32'h0F0F_0F0F, 6'd16};
    str_vec[3] = '{32'h7FFF_FFFF, 6'd31};

    // Reset held with in_valid asserted
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_count", {26'd0, out_count}, 32'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_reset_valid", {31'd0, out_valid}, 32'd0);

    // Boundaries: isolated words, exact 2-cycle latency
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = bnd_vec[i].data;
      tick();
      in_valid = 1'b0;
      in_data  = 32'hDEAD_BEEF;
      chk("bnd_early_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("bnd_valid", {31'd0, out_valid}, 32'd1);
      chk("bnd_count", {26'd0, out_count}, {26'd0, bnd_vec[i].cnt});
      tick();
      chk("bnd_late_valid", {31'd0, out_valid}, 32'd0);
      chk("bnd_hold", {26'd0, out_count}, {26'd0, bnd_vec[i].cnt});
    end

    // Streaming back-to-back
    for (int j = 0; j < 6; j++) begin
      in_valid = (j < 4);
      in_data  = (j < 4) ? str_vec[j].data : 32'h1234_5678;
      tick();
      if (j >= 1 && j <= 4) begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_count", {26'd0, out_count}, {26'd0, str_vec[j-1].cnt});
      end else begin
        chk("stream_idle_valid", {31'd0, out_valid}, 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();

    // Bubble pattern 1,0,1
    in_valid = 1'b1; in_data = 32'h0000_0003; tick();
    in_valid = 1'b0; in_data = 32'hFFFF_FFFF; tick();
    chk("bub_v0", {31'd0, out_valid}, 32'd1);
    chk("bub_c0", {26'd0, out_count}, 32'd2);
    in_valid = 1'b1; in_data = 32'hF000_000F; tick();
    chk("bub_v1", {31'd0, out_valid}, 32'd0);
    chk("bub_c1_hold", {26'd0, out_count}, 32'd2);
    in_valid = 1'b0; in_data = 32'h0; tick();
    chk("bub_v2", {31'd0, out_valid}, 32'd1);
    chk("bub_c2", {26'd0, out_count}, 32'd8);
    tick();
    chk("bub_v3", {31'd0, out_valid}, 32'd0);
    chk("bub_c3_hold", {26'd0, out_count}, 32'd8);

    // Mid-stream reset: first word in stage 1, second word presented on reset edge
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tick();
    rst_n = 1'b0;    in_data = 32'h0000_FFFF; tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {26'd0, out_count}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; tick();
    chk("mid_rel_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mid_rel_valid1", {31'd0, out_valid}, 32'd0);
    chk("mid_rel_count", {26'd0, out_count}, 32'd0);
    in_valid = 1'b1; in_data = 32'h0000_FFFF; tick();
    in_valid = 1'b0; tick();
    chk("mid_first_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_first_count", {26'd0, out_count}, 32'd16);
    tick();

    // Random stream against $countones scoreboard
    mv1 = 1'b0;
    mv2 = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom();
      if (in_valid) q.push_back(6'($countones(in_data)));
      tick();
      mv2 = mv1;
      mv1 = in_valid;
      chk("rand_valid", {31'd0, out_valid}, {31'd0, mv2});
      if (mv2 && out_valid === 1'b1) begin
        if (q.size() > 0) begin
          exp_c = q.pop_front();
          chk("rand_count", {26'd0, out_count}, {26'd0, exp_c});
        end else begin
          chk("rand_queue_empty", 32'd1, {31'd0, 1'b0});
        end
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    if (q.size() > 0) begin
      exp_c = q.pop_front();
      chk("rand_tail_count", {26'd0, out_count}, {26'd0, exp_c});
    end
    chk("rand_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
